vga_sync_monitor: RTL

//  Receiving end of the VGA interface: samples VGA_HS/VGA_VS/VGA_R/G/B as driven by the game,

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_edge_sync.sv | 42 ++++
 rtl/vga_sync_monitor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480@60 raster constants, the sync-monitor FSM state encoding
//   and a small counter helper. Used by the VGA drivers and the sync monitor.
//   No ports.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int PIX_DIV   = 4;
    localparam bit SYNC_POL  = 1'b0;

    // Width of the pixel/line counters and coordinates.
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ALIGN = 2'd1,
        LOCK  = 2'd2
    } vga_mon_state_e;

    // Increment that wraps to zero after 'last'.
    function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] cnt,
                                                      input logic [CNT_W-1:0] last);
        return (cnt == last) ? '0 : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// vga_edge_sync
//   Registers one sync line twice and flags assertion / deassertion edges
//   between the two copies, interpreting the level through ACTIVE_LVL.
// Ports
//   clk_i        system clock
//   rst_ni       synchronous reset, active-low
//   sync_i       raw sync input
//   assert_o     stage-1 active, stage-2 inactive
//   deassert_o   stage-1 inactive, stage-2 active
module vga_edge_sync #(
    parameter bit ACTIVE_LVL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic assert_o,
    output logic deassert_o
);

    logic s1_q;
    logic s2_q;
    logic act1;
    logic act2;

    // Both stages follow the pin during reset so that releasing reset while
    // the sync is held active does not fabricate an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= sync_i;
            s2_q <= sync_i;
        end else begin
            s1_q <= sync_i;
            s2_q <= s1_q;
        end
    end

    assign act1       = (s1_q == ACTIVE_LVL);
    assign act2       = (s2_q == ACTIVE_LVL);
    assign assert_o   = act1 & ~act2;
    assign deassert_o = ~act1 & act2;

endmodule

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Passive checker on a VGA stream: recovers the raster from HS/VS, reports
//   visible pixels with coordinates and colour, captures the colour at a
//   probe coordinate, verifies sync timing and counts locked frames.
// Ports
//   CLK, RST_BTN        clock, synchronous active-low reset
//   VGA_HS, VGA_VS      syncs under test
//   VGA_R/G/B           4-bit colour channels under test
//   PROBE_X, PROBE_Y    probe coordinate
//   pix_valid/x/y/rgb   recovered visible pixel (one-cycle strobe)
//   probe_rgb/valid     colour captured at the probe, update pulse
//   locked              raster timing verified
//   frame_count         completed locked frames (wraps)
//   err_hs, err_vs      one-cycle timing violation pulses
//
// state | meaning
// HUNT  | no reference; timing checks disabled, waiting for a VS edge
// ALIGN | counters loaded from one VS edge, checking the next frame
// LOCK  | raster verified; pixels reported, frames counted
module vga_sync_monitor
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP,
    parameter int PIX_DIV   = vga_timing_pkg::PIX_DIV,
    parameter bit SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
    input  logic             CLK,
    input  logic             RST_BTN,
    input  logic             VGA_HS,
    input  logic             VGA_VS,
    input  logic [3:0]       VGA_R,
    input  logic [3:0]       VGA_G,
    input  logic [3:0]       VGA_B,
    input  logic [CNT_W-1:0] PROBE_X,
    input  logic [CNT_W-1:0] PROBE_Y,
    output logic             pix_valid,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [11:0]      pix_rgb,
    output logic [11:0]      probe_rgb,
    output logic             probe_valid,
    output logic             locked,
    output logic [15:0]      frame_count,
    output logic             err_hs,
    output logic             err_vs
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_AS   = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] H_DE   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_AS   = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] V_DE   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

    localparam int                DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic hs_as, hs_de, vs_as, vs_de;

    vga_edge_sync #(.ACTIVE_LVL(SYNC_POL)) u_hs_sync (
        .clk_i      (CLK),
        .rst_ni     (RST_BTN),
        .sync_i     (VGA_HS),
        .assert_o   (hs_as),
        .deassert_o (hs_de)
    );

    vga_edge_sync #(.ACTIVE_LVL(SYNC_POL)) u_vs_sync (
        .clk_i      (CLK),
        .rst_ni     (RST_BTN),
        .sync_i     (VGA_VS),
        .assert_o   (vs_as),
        .deassert_o (vs_de)
    );

    vga_mon_state_e   state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, div_cur;
    logic [CNT_W-1:0] h_cnt_q, h_d, h_adv;
    logic [CNT_W-1:0] v_cnt_q, v_d, v_cur;
    logic [11:0]      rgb_s1_q;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             pix_valid_q, pix_valid_d;
    logic [CNT_W-1:0] pix_x_q, pix_y_q;
    logic [11:0]      pix_rgb_q, probe_rgb_q;
    logic             probe_valid_q, probe_hit;
    logic             err_hs_q, err_vs_q;
    logic             strobe, h_wrap, h_err, v_err, hunting;

    always_comb begin
        div_cur       = hs_as ? '0 : div_q;
        strobe        = (div_cur == '0);
        div_d         = (div_cur == DIV_LAST) ? '0 : div_cur + DIV_W'(1);

        // H load takes priority over the advance, so a line start never
        // wraps on the same cycle as an HS edge.
        h_adv         = cnt_wrap_inc(h_cnt_q, H_LAST);
        h_d           = h_cnt_q;
        h_wrap        = 1'b0;
        if (hs_as) begin
            h_d = H_AS;
        end else if (strobe) begin
            h_d    = h_adv;
            h_wrap = (h_adv == '0);
        end

        // v_cur is the line this cycle belongs to; V checks compare against it.
        v_cur         = h_wrap ? cnt_wrap_inc(v_cnt_q, V_LAST) : v_cnt_q;
        v_d           = vs_as ? V_AS : v_cur;

        hunting       = (state_q == HUNT);
        h_err         = !hunting && ((hs_as && (h_adv != H_AS)) ||
                                     (hs_de && !(strobe && (h_adv == H_DE))));
        v_err         = !hunting && ((vs_as && (v_cur != V_AS)) ||
                                     (vs_de && (v_cur != V_DE)));

        state_d = state_q;
        case (state_q)
            HUNT:    if (vs_as) state_d = ALIGN;
            ALIGN:   if (vs_as) state_d = LOCK;
            LOCK:    state_d = LOCK;
            default: state_d = HUNT;
        endcase
        if (h_err || v_err) state_d = HUNT;

        frame_count_d = frame_count_q;
        if ((state_q == LOCK) && vs_as && !h_err && !v_err)
            frame_count_d = frame_count_q + 16'd1;

        pix_valid_d   = (state_q == LOCK) && strobe && (h_d < H_VIS) && (v_d < V_VIS);
        probe_hit     = pix_valid_q && (pix_x_q == PROBE_X) && (pix_y_q == PROBE_Y);
    end

    always_ff @(posedge CLK) begin
        if (!RST_BTN) state_q <= HUNT;
        else          state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (!RST_BTN) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            rgb_s1_q      <= '0;
            frame_count_q <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            probe_rgb_q   <= '0;
            probe_valid_q <= 1'b0;
            err_hs_q      <= 1'b0;
            err_vs_q      <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_d;
            v_cnt_q       <= v_d;
            rgb_s1_q      <= {VGA_R, VGA_G, VGA_B};
            frame_count_q <= frame_count_d;
            pix_valid_q   <= pix_valid_d;
            if (pix_valid_d) begin
                pix_x_q   <= h_d;
                pix_y_q   <= v_d;
                pix_rgb_q <= rgb_s1_q;
            end
            probe_valid_q <= probe_hit;
            if (probe_hit) probe_rgb_q <= pix_rgb_q;
            err_hs_q      <= h_err;
            err_vs_q      <= v_err;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign probe_rgb   = probe_rgb_q;
    assign probe_valid = probe_valid_q;
    assign locked      = (state_q == LOCK);
    assign frame_count = frame_count_q;
    assign err_hs      = err_hs_q;
    assign err_vs      = err_vs_q;

endmodule
